// File: rtl/flp_pkg_v2.sv
// Shared types and constants for the parametrised floating-point datapath.
package flp_pkg_v2;

  typedef enum logic [2:0] {
    ClsZero,
    ClsNormal,
    ClsInf,
    ClsQnan,
    ClsSnan
  } flp_class_t;

  // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  // Widest word the constant helpers can build; callers slice down to their width
  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned flp_bias(input int unsigned exp_bits);
    return (32'd1 << (exp_bits - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
  function automatic logic [MaxWidth-1:0] flp_qnan(input int unsigned exp_bits,
                                                   input int unsigned frac_bits);
    logic [MaxWidth-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < exp_bits; i++) begin
      w[frac_bits + i] = 1'b1;
    end
    w[frac_bits - 1] = 1'b1;
    return w;
  endfunction

  // Subnormal encodings (exp == 0) classify as zero, which implements flush-to-zero
  function automatic flp_class_t flp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero, input logic frac_msb);
    if (exp_zero) return ClsZero;
    else if (!exp_ones) return ClsNormal;
    else if (frac_zero) return ClsInf;
    else if (frac_msb) return ClsQnan;
    else return ClsSnan;
  endfunction

endpackage

// File: rtl/flp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns Width.
module flp_lzc #(
  parameter int unsigned Width = 57,
  localparam int unsigned CntW = $clog2(Width + 1)
) (
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  count_o
);

  // Scan upward so the highest set bit makes the final assignment
  always_comb begin
    count_o = CntW'(Width);
    for (int unsigned i = 0; i < Width; i++) begin
      if (data_i[i]) count_o = CntW'(Width - 1 - i);
    end
  end

endmodule

// File: rtl/flp_add_sub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with RNE rounding,
// flush-to-zero, special-value handling, sideband tag and global-stall backpressure.
module flp_add_sub_pipe
  import flp_pkg_v2::*;
#(
  parameter int unsigned EXP_BITS  = 11,
  parameter int unsigned FRAC_BITS = 52,
  parameter int unsigned TAG_BITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_BITS+FRAC_BITS:0] in_a,
  input  logic [EXP_BITS+FRAC_BITS:0] in_b,
  input  logic                        in_sub,
  input  logic [TAG_BITS-1:0]         in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_BITS+FRAC_BITS:0] out_result,
  output logic [TAG_BITS-1:0]         out_tag,
  output logic [3:0]                  out_flags
);

  localparam int unsigned W  = 1 + EXP_BITS + FRAC_BITS;
  localparam int unsigned MW = FRAC_BITS + 4;  // {hidden, frac, guard, round, sticky}
  localparam int unsigned SW = MW + 1;         // plus carry-out
  localparam int unsigned CW = $clog2(SW + 1);
  localparam int unsigned XW = ((EXP_BITS > CW) ? EXP_BITS : CW) + 2;

  localparam logic [MaxWidth-1:0]  QnanWide = flp_qnan(EXP_BITS, FRAC_BITS);
  localparam logic [W-1:0]         Qnan     = QnanWide[W-1:0];
  localparam logic [EXP_BITS-1:0]  ExpOnes  = '1;
  localparam logic signed [XW-1:0] ExpTop   = XW'((1 << EXP_BITS) - 1);
  localparam logic signed [XW-1:0] ExpOne   = XW'(1);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic                 a_s, b_s;
  logic [EXP_BITS-1:0]  a_e, b_e;
  logic [FRAC_BITS-1:0] a_f, b_f;
  flp_class_t           a_cls, b_cls;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_s = in_a[W-1];
  assign a_e = in_a[W-2:FRAC_BITS];
  assign a_f = in_a[FRAC_BITS-1:0];
  assign b_s = in_b[W-1] ^ in_sub;
  assign b_e = in_b[W-2:FRAC_BITS];
  assign b_f = in_b[FRAC_BITS-1:0];

  assign a_cls  = flp_classify(a_e == '0, a_e == ExpOnes, a_f == '0, a_f[FRAC_BITS-1]);
  assign b_cls  = flp_classify(b_e == '0, b_e == ExpOnes, b_f == '0, b_f[FRAC_BITS-1]);
  assign a_nan  = (a_cls == ClsQnan) || (a_cls == ClsSnan);
  assign b_nan  = (b_cls == ClsQnan) || (b_cls == ClsSnan);
  assign a_inf  = (a_cls == ClsInf);
  assign b_inf  = (b_cls == ClsInf);
  assign a_zero = (a_cls == ClsZero);
  assign b_zero = (b_cls == ClsZero);

  logic                 a_ge, sml_s;
  logic [EXP_BITS-1:0]  sml_e, shamt;
  logic [FRAC_BITS-1:0] big_f, sml_f;
  logic [MW-1:0]        mb;
  logic                 s1_sign_d, s1_eff_sub_d, s1_spec_d;
  logic [EXP_BITS-1:0]  s1_exp_d;
  logic [MW-1:0]        s1_ma_d, s1_mb_d;
  logic [W-1:0]         s1_spec_res_d;
  logic [3:0]           s1_spec_flags_d;

  // Order operands by magnitude and shift the smaller one into guard/round/sticky
  always_comb begin
    a_ge         = {a_e, a_f} >= {b_e, b_f};
    s1_sign_d    = a_ge ? a_s : b_s;
    sml_s        = a_ge ? b_s : a_s;
    s1_exp_d     = a_ge ? a_e : b_e;
    big_f        = a_ge ? a_f : b_f;
    sml_e        = a_ge ? b_e : a_e;
    sml_f        = a_ge ? b_f : a_f;
    s1_eff_sub_d = s1_sign_d ^ sml_s;
    shamt        = s1_exp_d - sml_e;
    s1_ma_d      = {1'b1, big_f, 3'b000};
    mb           = {1'b1, sml_f, 3'b000};
    if (int'(shamt) >= int'(MW)) begin
      s1_mb_d = MW'(1);
    end else begin
      s1_mb_d    = mb >> shamt;
      s1_mb_d[0] = s1_mb_d[0] | (|(mb & ~({MW{1'b1}} << shamt)));
    end
  end

  // Results that bypass the arithmetic path: NaN, Inf, and any zero operand
  always_comb begin
    s1_spec_d       = 1'b1;
    s1_spec_res_d   = '0;
    s1_spec_flags_d = '0;
    if (a_nan || b_nan) begin
      s1_spec_res_d                = Qnan;
      s1_spec_flags_d[FlagInvalid] = (a_cls == ClsSnan) || (b_cls == ClsSnan);
    end else if (a_inf && b_inf && (a_s != b_s)) begin
      s1_spec_res_d                = Qnan;
      s1_spec_flags_d[FlagInvalid] = 1'b1;
    end else if (a_inf) begin
      s1_spec_res_d = {a_s, ExpOnes, {FRAC_BITS{1'b0}}};
    end else if (b_inf) begin
      s1_spec_res_d = {b_s, ExpOnes, {FRAC_BITS{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_spec_res_d = {a_s & b_s, {(W-1){1'b0}}};
    end else if (a_zero) begin
      s1_spec_res_d = {b_s, b_e, b_f};
    end else if (b_zero) begin
      s1_spec_res_d = {a_s, a_e, a_f};
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  logic                s1_valid, s1_sign, s1_eff_sub, s1_spec;
  logic [TAG_BITS-1:0] s1_tag;
  logic [EXP_BITS-1:0] s1_exp;
  logic [MW-1:0]       s1_ma, s1_mb;
  logic [W-1:0]        s1_spec_res;
  logic [3:0]          s1_spec_flags;

  // ---------------- S2: significand add/subtract and LZC ----------------
  logic [SW-1:0] s2_sum_d;
  logic [CW-1:0] s2_lzc_d;

  assign s2_sum_d = s1_eff_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb})
                               : ({1'b0, s1_ma} + {1'b0, s1_mb});

  flp_lzc #(
    .Width(SW)
  ) u_lzc (
    .data_i (s2_sum_d),
    .count_o(s2_lzc_d)
  );

  logic                s2_valid, s2_sign, s2_spec;
  logic [TAG_BITS-1:0] s2_tag;
  logic [EXP_BITS-1:0] s2_exp;
  logic [SW-1:0]       s2_sum;
  logic [CW-1:0]       s2_lzc;
  logic [W-1:0]        s2_spec_res;
  logic [3:0]          s2_spec_flags;

  // Stage datapath registers; validity is tracked separately with reset
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_tag        <= in_tag;
      s1_sign       <= s1_sign_d;
      s1_eff_sub    <= s1_eff_sub_d;
      s1_exp        <= s1_exp_d;
      s1_ma         <= s1_ma_d;
      s1_mb         <= s1_mb_d;
      s1_spec       <= s1_spec_d;
      s1_spec_res   <= s1_spec_res_d;
      s1_spec_flags <= s1_spec_flags_d;
      s2_tag        <= s1_tag;
      s2_sign       <= s1_sign;
      s2_exp        <= s1_exp;
      s2_sum        <= s2_sum_d;
      s2_lzc        <= s2_lzc_d;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [SW-1:0]          norm;
  logic [FRAC_BITS:0]     kept;
  logic [FRAC_BITS+1:0]   kept_r;
  logic                   grd, stk, rnd_up;
  logic signed [XW-1:0]   exp_n, exp_f;
  logic [FRAC_BITS-1:0]   frac_f;
  logic [W-1:0]           res_d;
  logic [3:0]             flags_d;

  // A carry-out gives lzc 0, so one left shift by lzc covers both normalisation directions
  always_comb begin
    norm    = s2_sum << s2_lzc;
    kept    = norm[SW-1:4];
    grd     = norm[3];
    stk     = |norm[2:0];
    rnd_up  = grd & (stk | kept[0]);
    kept_r  = {1'b0, kept} + {{(FRAC_BITS+1){1'b0}}, rnd_up};
    exp_n   = $signed({{(XW-EXP_BITS){1'b0}}, s2_exp}) + ExpOne
              - $signed({{(XW-CW){1'b0}}, s2_lzc});
    if (kept_r[FRAC_BITS+1]) begin
      exp_f  = exp_n + ExpOne;
      frac_f = kept_r[FRAC_BITS:1];
    end else begin
      exp_f  = exp_n;
      frac_f = kept_r[FRAC_BITS-1:0];
    end
    res_d   = '0;
    flags_d = '0;
    if (s2_spec) begin
      res_d   = s2_spec_res;
      flags_d = s2_spec_flags;
    end else if (s2_sum == '0) begin
      res_d = '0;
    end else if (exp_f >= ExpTop) begin
      res_d                  = {s2_sign, ExpOnes, {FRAC_BITS{1'b0}}};
      flags_d[FlagOverflow]  = 1'b1;
      flags_d[FlagInexact]   = 1'b1;
    end else if (exp_f < ExpOne) begin
      res_d                  = {s2_sign, {(W-1){1'b0}}};
      flags_d[FlagUnderflow] = 1'b1;
      flags_d[FlagInexact]   = 1'b1;
    end else begin
      res_d                = {s2_sign, exp_f[EXP_BITS-1:0], frac_f};
      flags_d[FlagInexact] = grd | stk;
    end
  end

  // Valid chain and output registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_result <= res_d;
        out_tag    <= s2_tag;
        out_flags  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_flp_add_sub_pipe.sv
// Scoreboard bench for flp_add_sub_pipe (double precision, 8-bit tag).
module tb_flp_add_sub_pipe;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [7:0]  tag;
    logic [63:0] res;
    logic [3:0]  flags;
  } op_t;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  tag;
    logic [3:0]  flags;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [7:0]  out_tag;
  logic [3:0]  out_flags;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stall_lo = -1;
  int   stall_hi = -1;
  bit   check_lat = 1'b0;
  bit   rand_ready = 1'b0;
  bit   rst_req = 1'b1;
  op_t  stim_q[$];
  exp_t sb_q[$];

  flp_add_sub_pipe #(
    .EXP_BITS (11),
    .FRAC_BITS(52),
    .TAG_BITS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                input logic [7:0] tag, input logic [63:0] res,
                                input logic [3:0] flags);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.tag = tag; o.res = res; o.flags = flags;
    return o;
  endfunction

  // Reference from host IEEE doubles; exactness via the Fast2Sum error term
  function automatic op_t mk_rand(input logic [7:0] tag);
    op_t o;
    real ra, rb, rs;
    bit  exact;
    o.a   = {1'($urandom_range(0, 1)), 11'($urandom_range(1000, 1050)),
             20'($urandom), 32'($urandom)};
    o.b   = {1'($urandom_range(0, 1)), 11'($urandom_range(1000, 1050)),
             20'($urandom), 32'($urandom)};
    o.sub = 1'($urandom_range(0, 1));
    o.tag = tag;
    ra = $bitstoreal(o.a);
    rb = $bitstoreal(o.b);
    if (o.sub) rb = -rb;
    rs = ra + rb;
    if (((ra < 0.0) ? -ra : ra) >= ((rb < 0.0) ? -rb : rb)) exact = ((rs - ra) == rb);
    else exact = ((rs - rb) == ra);
    o.res   = (rs == 0.0) ? 64'h0 : $realtobits(rs);
    o.flags = {3'b000, ~exact};
    return o;
  endfunction

  // One cycle: drive at negedge, then judge both handshakes once inputs have settled
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    rst = rst_req;
    if (stim_q.size() > 0) begin
      in_valid = 1'b1;
      in_a     = stim_q[0].a;
      in_b     = stim_q[0].b;
      in_sub   = stim_q[0].sub;
      in_tag   = stim_q[0].tag;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 64'(out_valid), 64'd0);
      end else if (out_ready) begin
        e = sb_q.pop_front();
        check_eq("result", out_result, e.res);
        check_eq("tag", 64'(out_tag), 64'(e.tag));
        check_eq("flags", 64'(out_flags), 64'(e.flags));
        if (check_lat) check_eq("latency", 64'(cyc - int'(e.cyc)), 64'd3);
      end else begin
        check_eq("stall_hold_result", out_result, sb_q[0].res);
        check_eq("stall_hold_tag", 64'(out_tag), 64'(sb_q[0].tag));
        check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      end
    end
    if (rst) begin
      if (in_valid) stim_q.delete(0);
      sb_q.delete();
    end else if (in_valid && in_ready) begin
      e.res   = stim_q[0].res;
      e.tag   = stim_q[0].tag;
      e.flags = stim_q[0].flags;
      e.cyc   = 32'(cyc);
      sb_q.push_back(e);
      stim_q.delete(0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (stim_q.size() == 0 && sb_q.size() == 0) break;
      step();
    end
    check_eq("drain_empty", 64'(stim_q.size() + sb_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    // Reset state
    rst_req = 1'b1;
    step();
    step();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_result", out_result, 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_out_flags", 64'(out_flags), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    rst_req = 1'b0;

    // Directed vectors, no backpressure, latency checked
    check_lat = 1'b1;
    stim_q.push_back(mk_op(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 8'h5A,
                           64'h4008000000000000, 4'b0000));
    stim_q.push_back(mk_op(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 8'h01,
                           64'h3FF0000000000000, 4'b0001));
    stim_q.push_back(mk_op(64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 8'h02,
                           64'h3FF0000000000002, 4'b0001));
    stim_q.push_back(mk_op(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 8'h03,
                           64'h0000000000000000, 4'b0000));
    stim_q.push_back(mk_op(64'h8000000000000000, 64'h8000000000000000, 1'b0, 8'h04,
                           64'h8000000000000000, 4'b0000));
    stim_q.push_back(mk_op(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 8'h05,
                           64'h7FF0000000000000, 4'b0101));
    stim_q.push_back(mk_op(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 8'h06,
                           64'h7FF8000000000000, 4'b1000));
    stim_q.push_back(mk_op(64'h0010000000000001, 64'h0010000000000000, 1'b1, 8'h07,
                           64'h0000000000000000, 4'b0011));
    stim_q.push_back(mk_op(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 8'h08,
                           64'h7FF8000000000000, 4'b1000));
    stim_q.push_back(mk_op(64'hFFF8000000000000, 64'h3FF0000000000000, 1'b0, 8'h09,
                           64'h7FF8000000000000, 4'b0000));
    stim_q.push_back(mk_op(64'h3FF0000000000000, 64'hFFF0000000000000, 1'b0, 8'h0A,
                           64'hFFF0000000000000, 4'b0000));
    stim_q.push_back(mk_op(64'h000123456789ABCD, 64'h4000000000000000, 1'b1, 8'h0B,
                           64'hC000000000000000, 4'b0000));
    drain();

    // Backpressure: 10 back-to-back ops, out_ready low for cycles 4-8
    check_lat = 1'b0;
    base = cyc;
    stall_lo = base + 4;
    stall_hi = base + 8;
    for (int i = 0; i < 10; i++) stim_q.push_back(mk_rand(8'(i)));
    drain();
    stall_lo = -1;
    stall_hi = -1;

    // Random stream with random downstream readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) stim_q.push_back(mk_rand(8'(8'h40 + i)));
    drain();
    rand_ready = 1'b0;

    // Reset mid-flight: reset lands on the edge that would emit the first op
    stim_q.push_back(mk_rand(8'hA0));
    stim_q.push_back(mk_rand(8'hA1));
    stim_q.push_back(mk_rand(8'hA2));
    step();
    step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("post_rst_valid", 64'(out_valid), 64'd0);
    end
    check_lat = 1'b1;
    stim_q.push_back(mk_op(64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 8'hC3,
                           64'h3FF0000000000000, 4'b0000));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flp_add_sub_pipe.md
Name: flp_add_sub_pipe

Overview:
Parametrised, fully pipelined floating-point adder/subtractor for the NTT floating-point datapath, and successor to the fixed two-stage adder.
- Generalises exponent/fraction width.
- Selects add or subtract per operation at runtime instead of at elaboration.
- Adds round-to-nearest-even, special-value handling, exception flags, a pass-through tag and valid/ready backpressure.
- Sits between the twiddle multiplier and the butterfly output registers.

Parameters:
EXP_BITS, 11, exponent field width (bias = 2^(EXP_BITS-1)-1)
FRAC_BITS, 52, stored fraction width (hidden bit implicit)
TAG_BITS, 8, width of opaque sideband tag carried alongside each operation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation presented
in_ready  out  1  block accepts operation this cycle
in_a  in  1+EXP_BITS+FRAC_BITS  operand a {sign,exp,frac}
in_b  in  1+EXP_BITS+FRAC_BITS  operand b
in_sub  in  1  1: a-b, 0: a+b
in_tag  in  TAG_BITS  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  1+EXP_BITS+FRAC_BITS  rounded result
out_tag  out  TAG_BITS  tag of this result
out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, out_result=0, out_tag=0, out_flags=0. Reset mid-operation discards all in-flight operations; no partial results emerge.
- Latency 3 cycles from accept (in_valid&in_ready) to out_valid, with no stall. Throughput is 1 op/cycle.
- Global stall: stall = out_valid & ~out_ready. While stalled, every stage register holds and in_ready=0. in_ready = ~stall is combinational from out_ready.
- Bubbles propagate: a stage with valid=0 never blocks the stages behind it.
- out_result, out_tag and out_flags stay stable while out_valid=1 and out_ready=0.
- S1 unpack/align:
  - Effective sign of b = b.sign ^ in_sub.
  - Inputs with exp=0 flush to signed zero (FTZ).
  - Classify NaN/Inf/zero.
  - Swap so |A| >= |B| (compare exp, then fraction).
  - Right-shift B's significand by the exponent difference into guard/round/sticky. A shift >= FRAC_BITS+3 leaves B as sticky only.
- S2 add:
  - Signs equal: add significands; otherwise subtract (A-B, never negative).
  - Compute leading-zero count of the sum.
- S3 normalize/round/pack:
  - Carry-out shifts right 1 and increments the exponent.
  - Otherwise shift left by the LZC and decrement the exponent.
  - Round-to-nearest-even on guard/round/sticky. A rounding carry renormalises.
- Special cases:
  - Any NaN input → canonical qNaN (exp all-ones, frac MSB=1, sign 0). invalid=1 only for a signalling NaN input.
  - Inf + (-Inf) → canonical qNaN, invalid=1.
  - Inf with a finite operand → that Inf.
  - Exact zero sum of opposite-sign operands → +0.
  - (-0)+(-0) → -0.
- Overflow (biased exp >= all-ones after rounding) → signed Inf, overflow=1, inexact=1.
- Underflow (biased exp < 1) → signed zero (FTZ), underflow=1, inexact=1.
- inexact=1 whenever any discarded bit is nonzero.
- Flags apply per result; they are not sticky across operations.

Decomposition:
- Shared package flp_pkg_v2: flp_class_t enum (ZERO, NORMAL, INF, QNAN, SNAN), flag index constants, and the canonical-NaN and bias constant functions parametrised on EXP_BITS/FRAC_BITS.
- One sub-module: flp_lzc (parametrised leading-zero counter, combinational), instantiated in S2.

Test Plan:
- in_a=0x3FF0000000000000 (1.0), in_b=0x4000000000000000 (2.0), in_sub=0, tag=0x5A → 3 cycles later out_result=0x4008000000000000 (3.0), out_tag=0x5A, flags=0000.
- RNE tie: 0x3FF0000000000000 + 0x3CA0000000000000 (2^-53) → 0x3FF0000000000000, inexact=1. Then 0x3FF0000000000001 + 0x3CA0000000000000 → 0x3FF0000000000002, inexact=1.
- Cancellation: 1.0 with in_sub=1, b=1.0 → 0x0000000000000000 (+0), flags=0000. 0x8000000000000000 + 0x8000000000000000 → 0x8000000000000000.
- Overflow: 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000, overflow=1, inexact=1. Inf-Inf (0x7FF0000000000000, sub=1) → 0x7FF8000000000000, invalid=1.
- Backpressure: stream 10 ops back-to-back with out_ready held 0 for cycles 4-8 → in_ready=0 during stall, no op lost or duplicated, tags emerge in order 0..9, outputs stable while stalled.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle → out_valid stays 0, no stale result ever appears. The next accepted op emerges after exactly 3 cycles.
